mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle sequencer for the multiply/divide unit of the 54-instruction single-cycle CPU. It accepts the MDU operation code and operands decoded by the control unit, runs an iterative 32-step shift-add multiplier or restoring divider, and owns the HI/LO registers. While an operation is in flight it holds the PC stalled through `pc_ena`, so the same instruction and operands stay on its inputs until completion.

## Interface
- Parameters: none (width fixed at 32).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mduc`  in  3  op: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- `a`  in  32  rs operand (multiplicand / dividend / MTHI-MTLO source).
- `b`  in  32  rt operand (multiplier / divisor).
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `pc_ena`  out  1  1 = PC may advance; 0 = stall.
- `busy`  out  1  1 while state is BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `mduc` in {MULT, MULTU, DIV, DIVU}: latch |a|, |b| (signed ops) or a, b (unsigned), latch result sign bits, clear 64-bit accumulator, count := 0, go BUSY.
- IDLE, MTHI/MTLO: write `a` to HI/LO at the edge; stay IDLE; no stall.
- IDLE, none/reserved: hold.
- BUSY: one iteration per cycle; multiply = test LSB of multiplier, add multiplicand to upper half, shift right 1; divide = shift remainder:quotient left 1, subtract divisor if no borrow, set quotient LSB. After count = 31 go DONE.
- DONE: apply sign correction (signed multiply: negate 64-bit product if signs differ; signed divide: quotient negated if signs differ, remainder takes dividend sign), write HI/LO at the DONE→IDLE edge, return IDLE. `mduc` is ignored in DONE (same instruction still presented).
- MULT/MULTU: HI:LO = 64-bit product. DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend (signed: LO = 0xFFFFFFFF, HI = a unchanged).
- 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0 (natural 32-bit wrap).
- HI/LO unchanged throughout BUSY; read values during a stall are the previous results.

## Timing
- Reset: state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `pc_ena` = 1 while `rst` high and after.
- `pc_ena` combinational: 0 when (IDLE and `mduc` is mult/div) or BUSY; 1 in DONE and otherwise.
- Iterative op occupies 34 cycles: cycle 0 IDLE (launch, stall), cycles 1–32 BUSY (stall), cycle 33 DONE (`pc_ena` = 1, PC advances at that edge together with HI/LO write).
- Instruction following a mult/div sees new HI/LO in its first cycle (MFHI/MFLO back-to-back correct).
- `rst` mid-operation: abort at the edge, HI/LO cleared, IDLE next cycle, no partial write.
- Operand changes during BUSY ignored (latched at launch).

## Configuration
- `MDU_FAST_MUL_EN` defined: MULT/MULTU computed with a single-cycle 32×32 multiplier; IDLE→DONE directly, stall of 1 cycle, HI/LO written at end of cycle 1. Divide unchanged.
- Undefined: both multiply and divide use the 32-iteration path (34-cycle occupancy).

## Test plan
- Reset then MULT a=0xFFFFFFFE, b=3 -> `pc_ena` low 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=0xFFFFFFFE, b=3 -> HI=0x00000002, LO=0xFFFFFFFA; with `MDU_FAST_MUL_EN` stall is exactly 1 cycle.
- DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI a=0xDEADBEEF then MTLO a=0x0000CAFE -> HI/LO updated next edge, `pc_ena` never low, `busy` stays 0.
- Launch DIV, assert `rst` at BUSY cycle 10 -> next cycle IDLE, HI=LO=0, `pc_ena`=1; a fresh MULT afterwards completes correctly.

Source files
------------

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; stalls the PC while an op is in flight.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier (divide stays iterative).
module mdu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mduc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        pc_ena,
    output logic        busy
);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opa_q, opa_d;
    logic [4:0]  count_q, count_d;
    logic        div_q, div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mult, is_div, is_signed;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_diff;
    logic [63:0] div_step;
    logic [63:0] prod_fix;
    logic [31:0] quot_mag, rem_mag, quot_fix, rem_fix;

    always_comb begin
        is_mult   = (mduc == OpMult) || (mduc == OpMultu);
        is_div    = (mduc == OpDiv) || (mduc == OpDivu);
        is_signed = (mduc == OpMult) || (mduc == OpDiv);
        mag_a     = (is_signed && a[31]) ? -a : a;
        mag_b     = (is_signed && b[31]) ? -b : b;
    end

    // opa_q holds the multiplicand for multiply and the divisor for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
        mul_step = {mul_sum, acc_q[31:1]};
        div_diff = acc_q[63:31] - {1'b0, opa_q};
        if (!div_diff[32]) begin
            div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_step = {acc_q[62:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quot_mag = acc_q[31:0];
        rem_mag  = acc_q[63:32];
        quot_fix = neg_lo_q ? -quot_mag : quot_mag;
        rem_fix  = neg_hi_q ? -rem_mag : rem_mag;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        count_d  = count_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            StIdle: begin
                if (is_mult || is_div) begin
                    opa_d    = is_div ? mag_b : mag_a;
                    acc_d    = {32'd0, is_div ? mag_a : mag_b};
                    count_d  = 5'd0;
                    div_d    = is_div;
                    // A zero divisor keeps the all-ones quotient regardless of signs.
                    neg_lo_d = is_signed && (a[31] ^ b[31]) && (is_mult || (b != 32'd0));
                    neg_hi_d = is_signed && is_div && a[31];
                    state_d  = StBusy;
`ifdef MDU_FAST_MUL_EN
                    if (is_mult) begin
                        acc_d   = 64'(mag_a) * 64'(mag_b);
                        state_d = StDone;
                    end
`endif
                end else if (mduc == OpMthi) begin
                    hi_d = a;
                end else if (mduc == OpMtlo) begin
                    lo_d = a;
                end
            end
            StBusy: begin
                acc_d   = div_q ? div_step : mul_step;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= 64'd0;
            opa_q    <= 32'd0;
            count_q  <= 5'd0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            count_q  <= count_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign pc_ena = rst || !(((state_q == StIdle) && (is_mult || is_div)) || (state_q == StBusy));
    assign busy   = !rst && (state_q != StIdle);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with hand-computed HI/LO results.
module tb_mdu_seq;

    localparam logic [2:0] OpNone  = 3'b000;
    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;
    localparam logic [2:0] OpRsvd  = 3'b111;

`ifdef MDU_FAST_MUL_EN
    localparam int MulStall = 1;
`else
    localparam int MulStall = 33;
`endif
    localparam int DivStall = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mduc;
    logic [31:0] a, b, hi, lo;
    logic        pc_ena, busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .mduc   (mduc),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .pc_ena (pc_ena),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch op, count stall cycles (operands scrambled after launch), then check results.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                          input int estall);
        int stall = 0;
        @(negedge clk);
        mduc = op;
        a    = av;
        b    = bv;
        #1;
        while (!pc_ena && stall < 100) begin
            stall++;
            @(negedge clk);
            a = ~av;
            b = ~bv;
            #1;
        end
        check({name, " stall"}, 64'(stall), 64'(estall));
        check({name, " busy_done"}, 64'(busy), 64'd1);
        check({name, " hi_held"}, 64'(hi), 64'(exp_hi));
        check({name, " lo_held"}, 64'(lo), 64'(exp_lo));
        mduc = OpNone;
        @(negedge clk);
        #1;
        check({name, " hi"}, 64'(hi), 64'(ehi));
        check({name, " lo"}, 64'(lo), 64'(elo));
        check({name, " busy_after"}, 64'(busy), 64'd0);
        check({name, " pc_ena_after"}, 64'(pc_ena), 64'd1);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    initial begin
        rst  = 1'b1;
        mduc = OpNone;
        a    = 32'd0;
        b    = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst pc_ena", 64'(pc_ena), 64'd1);
        rst = 1'b0;

        run_op("mult_neg2x3", OpMult, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MulStall);
        run_op("multu", OpMultu, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MulStall);
        run_op("mult_min_sq", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,
               MulStall);
        run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivStall);
        run_op("divu_m7_2", OpDivu, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, DivStall);
        run_op("divu_by0", OpDivu, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, DivStall);
        run_op("div_by0_neg", OpDiv, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DivStall);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DivStall);

        // MTHI/MTLO write at the edge without stalling.
        @(negedge clk);
        mduc = OpMthi;
        a    = 32'hDEAD_BEEF;
        #1;
        check("mthi pc_ena", 64'(pc_ena), 64'd1);
        check("mthi busy", 64'(busy), 64'd0);
        @(negedge clk);
        mduc = OpMtlo;
        a    = 32'h0000_CAFE;
        #1;
        check("mthi hi", 64'(hi), 64'hDEAD_BEEF);
        check("mtlo pc_ena", 64'(pc_ena), 64'd1);
        check("mtlo busy", 64'(busy), 64'd0);
        @(negedge clk);
        mduc = OpRsvd;
        #1;
        check("mtlo lo", 64'(lo), 64'h0000_CAFE);
        check("mtlo hi_kept", 64'(hi), 64'hDEAD_BEEF);
        check("rsvd pc_ena", 64'(pc_ena), 64'd1);
        @(negedge clk);
        #1;
        check("rsvd busy", 64'(busy), 64'd0);
        check("rsvd hi", 64'(hi), 64'hDEAD_BEEF);
        check("rsvd lo", 64'(lo), 64'h0000_CAFE);
        exp_hi = 32'hDEAD_BEEF;
        exp_lo = 32'h0000_CAFE;

        // Abort a divide partway through with reset.
        @(negedge clk);
        mduc = OpDiv;
        a    = 32'd100;
        b    = 32'd7;
        repeat (10) @(negedge clk);
        #1;
        check("abort busy_mid", 64'(busy), 64'd1);
        check("abort pc_ena_mid", 64'(pc_ena), 64'd0);
        check("abort hi_mid", 64'(hi), 64'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        check("abort pc_ena_rst", 64'(pc_ena), 64'd1);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mduc = OpNone;
        @(negedge clk);
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort pc_ena", 64'(pc_ena), 64'd1);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        run_op("mult_after_rst", OpMult, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6,
               MulStall);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
